// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and small helpers for the pipeline staging
//                blocks. Holds the skid buffer occupancy encoding and the
//                decode helpers that turn an occupancy state into the
//                handshake levels presented on the ports.
//  Contents    : skid_state_e      - occupancy of a two-entry skid buffer
//                skid_can_accept() - state has room for another beat
//                skid_has_head()   - state holds a beat at the output
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Occupancy of the two-entry skid buffer.
    //   SKID_EMPTY : nothing held, output invalid
    //   SKID_BUSY  : one beat held in the output register
    //   SKID_FULL  : output register plus the overflow (skid) register in use
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Upstream may push whenever the overflow slot is still free.
    function automatic logic skid_can_accept(input skid_state_e state);
        return (state != SKID_FULL);
    endfunction

    // Downstream sees a valid beat whenever anything is held.
    function automatic logic skid_has_head(input skid_state_e state);
        return (state != SKID_EMPTY);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/skid_buffer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Free-running event counter that sticks at all-ones instead
//                of wrapping. Used for the skid buffer statistics so that a
//                long-running stall is never misreported as a small count.
//  Parameters  : WIDTH    - counter width in bits
//  Ports       : clk_i    in   1      clock, posedge
//                rst_i    in   1      synchronous active-high clear
//                inc_i    in   1      count one event this cycle
//                count_o  out  WIDTH  current count (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    // Saturation point is the all-ones value of the counter width.
    assign w_at_max = (r_count == {WIDTH{1'b1}});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (inc_i && !w_at_max) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer
//  Description : Two-entry valid/ready pipeline stage that registers both
//                directions. The forward path (data/valid) and the backward
//                path (ready) come straight from flops, so the downstream
//                ready never reaches the upstream ready combinationally.
//                Sustains one beat per cycle and supports a synchronous
//                flush for branch redirects.
//  Parameters  : WIDTH      - payload width in bits
//                CNT_WIDTH  - statistics counter width (stats build only)
//  Ports       : clk_i        in   1          clock, posedge
//                rst_i        in   1          synchronous active-high reset
//                flush_i      in   1          drop all held beats this cycle
//                wr_valid_i   in   1          upstream beat valid
//                wr_data_i    in   WIDTH      upstream payload
//                wr_ready_o   out  1          buffer can accept (registered)
//                rd_ready_i   in   1          downstream accepts
//                rd_data_o    out  WIDTH      head payload (registered)
//                rd_valid_o   out  1          head valid (registered)
//                stall_cnt_o  out  CNT_WIDTH  upstream stall cycles   [stats]
//                xfer_cnt_o   out  CNT_WIDTH  beats taken downstream  [stats]
//  Build macro : SKID_BUFFER_STATS_EN - when defined, adds the saturating
//                stall/transfer counters and their ports. The datapath is
//                identical either way.
//  Revision    : 1.0  initial release
// ============================================================================
module skid_buffer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_valid_i,
    input  logic [WIDTH-1:0]     wr_data_i,
    output logic                 wr_ready_o,
    input  logic                 rd_ready_i,
    output logic [WIDTH-1:0]     rd_data_o,
    output logic                 rd_valid_o
`ifdef SKID_BUFFER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o
`endif
);

    import pipe_pkg::*;

    // ------------------------------------------------------------------------
    // Storage
    //   r_out  : head beat, drives rd_data_o directly
    //   r_skid : overflow beat, always younger than r_out
    // The two handshake outputs get their own flops, loaded from the decoded
    // next state, so the ports are pure flop outputs with no decode logic
    // between the register and the pin.
    // ------------------------------------------------------------------------
    skid_state_e      r_state;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_skid;
    logic             r_wr_ready;
    logic             r_rd_valid;

    skid_state_e      w_state_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_write;
    logic             w_read;

    // Handshakes qualify against the registered levels only.
    assign w_write = wr_valid_i && r_wr_ready;
    assign w_read  = r_rd_valid && rd_ready_i;

    // ------------------------------------------------------------------------
    // Next-state / next-data
    // Flush wins over any transfer: the state empties, a simultaneous write is
    // dropped, and a simultaneous read is simply allowed to complete (the
    // beat was already on the bus). Data registers are left stale on flush;
    // they are never observed until rewritten because valid goes low.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_skid_nxt  = r_skid;

        if (flush_i) begin
            w_state_nxt = SKID_EMPTY;
        end else begin
            unique case (r_state)
                SKID_EMPTY: begin
                    if (w_write) begin
                        w_out_nxt   = wr_data_i;
                        w_state_nxt = SKID_BUSY;
                    end
                end

                SKID_BUSY: begin
                    if (w_write && w_read) begin
                        // Head leaves as the new beat arrives: pass-through.
                        w_out_nxt = wr_data_i;
                    end else if (w_write) begin
                        // Head is stuck; park the new beat behind it.
                        w_skid_nxt  = wr_data_i;
                        w_state_nxt = SKID_FULL;
                    end else if (w_read) begin
                        w_state_nxt = SKID_EMPTY;
                    end
                end

                SKID_FULL: begin
                    // wr_ready is low here, so only a read can happen.
                    if (w_read) begin
                        w_out_nxt   = r_skid;
                        w_state_nxt = SKID_BUSY;
                    end
                end

                default: begin
                    // Unreachable encoding; recover to a clean empty state.
                    w_state_nxt = SKID_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and data registers. Reset clears both entries so the output
    // reads zero and the buffer is ready on the first cycle after release.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= SKID_EMPTY;
            r_out      <= '0;
            r_skid     <= '0;
            r_wr_ready <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_out      <= w_out_nxt;
            r_skid     <= w_skid_nxt;
            r_wr_ready <= skid_can_accept(w_state_nxt);
            r_rd_valid <= skid_has_head(w_state_nxt);
        end
    end

    assign wr_ready_o = r_wr_ready;
    assign rd_valid_o = r_rd_valid;
    assign rd_data_o  = r_out;

    // ------------------------------------------------------------------------
    // Optional statistics. Counters are cleared only by reset; flush is a
    // datapath event and deliberately leaves the history intact.
    // ------------------------------------------------------------------------
`ifdef SKID_BUFFER_STATS_EN
    logic w_stall;

    assign w_stall = wr_valid_i && !r_wr_ready;

    sat_counter #(
        .WIDTH   (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_stall),
        .count_o (stall_cnt_o)
    );

    sat_counter #(
        .WIDTH   (CNT_WIDTH)
    ) u_xfer_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_read),
        .count_o (xfer_cnt_o)
    );
`else
    // Keeps CNT_WIDTH referenced in the build without statistics.
    logic [CNT_WIDTH-1:0] w_unused_cnt_width;
    assign w_unused_cnt_width = '0;
`endif

endmodule : skid_buffer
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_skid_buffer
//  Description : Self-checking bench for skid_buffer. A queue-based model of
//                a two-deep FIFO predicts the outputs every cycle; directed
//                sequences pin the model with literal expectations, then a
//                long randomized valid/ready/flush/reset run follows.
//                With SKID_BUFFER_STATS_EN defined the counters are checked
//                too, using a 4-bit counter width.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_skid_buffer;

    localparam int unsigned WIDTH = 32;
`ifdef SKID_BUFFER_STATS_EN
    localparam int unsigned CNT_WIDTH = 4;
`else
    localparam int unsigned CNT_WIDTH = 32;
`endif
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             wr_valid_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             wr_ready_o;
    logic             rd_ready_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             rd_valid_o;
`ifdef SKID_BUFFER_STATS_EN
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] xfer_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    skid_buffer #(
        .WIDTH       (WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .wr_valid_i  (wr_valid_i),
        .wr_data_i   (wr_data_i),
        .wr_ready_o  (wr_ready_o),
        .rd_ready_i  (rd_ready_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o)
`ifdef SKID_BUFFER_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .xfer_cnt_o  (xfer_cnt_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a bounded FIFO of capacity two. Room = fewer than two
    // held; head visible = at least one held. Updated on each clock edge
    // from the inputs applied to that edge.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] mq[$];
    bit               model_live = 1'b0;
    longint unsigned  m_stall = 0;
    longint unsigned  m_xfer  = 0;

    always @(posedge clk_i) begin
        bit can_wr;
        bit do_rd;
        if (rst_i) begin
            mq.delete();
            m_stall    = 0;
            m_xfer     = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            can_wr = (mq.size() < 2);
            do_rd  = (mq.size() > 0) && rd_ready_i;
            if (wr_valid_i && !can_wr && m_stall < CNT_MAX) m_stall++;
            if (do_rd && m_xfer < CNT_MAX) m_xfer++;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (do_rd) void'(mq.pop_front());
                if (wr_valid_i && can_wr) mq.push_back(wr_data_i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Compare process: outputs vs. model on every falling edge, plus the
    // hold-while-stalled rule and a log of beats handed downstream.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] seen[$];
    bit               prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data;

    always @(negedge clk_i) begin
        if (model_live) begin
            check("rd_valid", 64'(rd_valid_o), 64'(mq.size() != 0));
            check("wr_ready", 64'(wr_ready_o), 64'(mq.size() < 2));
            if (mq.size() != 0) check("rd_data", 64'(rd_data_o), 64'(mq[0]));
            if (prev_hold) check("rd_data_hold", 64'(rd_data_o), 64'(prev_data));
`ifdef SKID_BUFFER_STATS_EN
            check("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
            check("xfer_cnt", 64'(xfer_cnt_o), 64'(m_xfer));
`endif
            if (rd_valid_o && rd_ready_i && !rst_i) seen.push_back(rd_data_o);
            prev_hold = rd_valid_o && !rd_ready_i && !flush_i && !rst_i;
            prev_data = rd_data_o;
        end
    end

    // Advance to just after the next rising edge (inputs change here).
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        wr_data_i  = '0;
        rd_ready_i = 1'b0;

        // ---------------- reset: two cycles, then check released state
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_rd_valid", 64'(rd_valid_o), 64'd0);
        check("reset_rd_data", 64'(rd_data_o), 64'd0);
        check("reset_wr_ready", 64'(wr_ready_o), 64'd1);

        // ---------------- streaming 0x1..0x10 with downstream always ready
        step();
        rd_ready_i = 1'b1;
        seen.delete();
        for (int i = 1; i <= 16; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = WIDTH'(i);
            @(negedge clk_i);
            if (i > 1) begin
                check("stream_valid", 64'(rd_valid_o), 64'd1);
                check("stream_latency", 64'(rd_data_o), 64'(i - 1));
            end
            step();
        end
        wr_valid_i = 1'b0;
        @(negedge clk_i);
        check("stream_last", 64'(rd_data_o), 64'h10);
        repeat (3) step();
        check("stream_count", 64'(seen.size()), 64'd16);
        for (int k = 0; k < seen.size() && k < 16; k++)
            check("stream_order", 64'(seen[k]), 64'(k + 1));

        // ---------------- backpressure: A, B fill, C held off, then drain
        rd_ready_i = 1'b0;
        seen.delete();
        wr_valid_i = 1'b1;
        wr_data_i  = 32'hA;
        step();
        wr_data_i  = 32'hB;
        step();
        wr_data_i  = 32'hC;
        @(negedge clk_i);
        check("bp_full_ready", 64'(wr_ready_o), 64'd0);
        check("bp_head", 64'(rd_data_o), 64'hA);
        step();
        @(negedge clk_i);
        check("bp_still_full", 64'(wr_ready_o), 64'd0);
        check("bp_head_hold", 64'(rd_data_o), 64'hA);
        step();
        rd_ready_i = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            @(negedge clk_i);
            if (wr_ready_o) acc = 1'b1;
            step();
        end
        wr_valid_i = 1'b0;
        check("bp_c_accepted", 64'(acc), 64'd1);
        repeat (4) step();
        check("bp_count", 64'(seen.size()), 64'd3);
        if (seen.size() == 3) begin
            check("bp_order_a", 64'(seen[0]), 64'hA);
            check("bp_order_b", 64'(seen[1]), 64'hB);
            check("bp_order_c", 64'(seen[2]), 64'hC);
        end

        // ---------------- flush while full, with a write of 0xD offered
        rd_ready_i = 1'b0;
        wr_valid_i = 1'b1;
        wr_data_i  = 32'h11;
        step();
        wr_data_i  = 32'h12;
        step();
        seen.delete();
        wr_data_i  = 32'hD;
        flush_i    = 1'b1;
        @(negedge clk_i);
        check("flush_pre_full", 64'(wr_ready_o), 64'd0);
        step();
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_rd_valid", 64'(rd_valid_o), 64'd0);
        check("flush_wr_ready", 64'(wr_ready_o), 64'd1);
        step();
        rd_ready_i = 1'b1;
        repeat (4) step();
        check("flush_nothing_out", 64'(seen.size()), 64'd0);

`ifdef SKID_BUFFER_STATS_EN
        // ---------------- counters: saturate stall at 0xF, flush keeps them
        rst_i = 1'b1;
        step();
        rst_i      = 1'b0;
        rd_ready_i = 1'b0;
        wr_valid_i = 1'b1;
        wr_data_i  = 32'h55;
        repeat (22) step();
        @(negedge clk_i);
        check("stats_stall_sat", 64'(stall_cnt_o), 64'hF);
        check("stats_xfer_zero", 64'(xfer_cnt_o), 64'h0);
        step();
        wr_valid_i = 1'b0;
        flush_i    = 1'b1;
        step();
        flush_i = 1'b0;
        @(negedge clk_i);
        check("stats_flush_stall", 64'(stall_cnt_o), 64'hF);
        check("stats_flush_xfer", 64'(xfer_cnt_o), 64'h0);
        step();
`endif

        // ---------------- randomized traffic against the model
        for (int c = 0; c < 10000; c++) begin
            wr_valid_i = ($urandom_range(0, 3) != 0);
            wr_data_i  = $urandom;
            rd_ready_i = (c % 1000 < 500) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 3) == 0);
            flush_i    = ($urandom_range(0, 99) == 0);
            rst_i      = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst_i      = 1'b0;
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_skid_buffer
`default_nettype wire
